ram_playback_reader: RTL and testbench
======================================

RAM_PLAYBACK_READER -- requirements
Module: ram_playback_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, RAM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 8, sample width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), sample buffer depth.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins playback at address 0.
REQ-007 SHALL have port stop  input  1  one-cycle pulse that aborts playback.
REQ-008 SHALL have port end_address  input  ADDR_W  last address to read (inclusive); sampled on the accepted start.
REQ-009 SHALL have port ram_rdy  input  1  RAM wrapper ready/calibrated.
REQ-010 SHALL have port address  output  ADDR_W  read address to the RAM wrapper.
REQ-011 SHALL have port read_request  output  1  read request to the RAM wrapper.
REQ-012 SHALL have port rd_data_pres  input  1  RAM read data valid.
REQ-013 SHALL have port data_out  input  DATA_W  RAM read data.
REQ-014 SHALL have port read_ack  output  1  acknowledge of consumed read data.
REQ-015 SHALL have port sample_req  input  1  one-cycle DAC sample strobe.
REQ-016 SHALL have port sample  output  DATA_W  current playback sample.
REQ-017 SHALL have port busy  output  1  playback in progress.
REQ-018 SHALL have port done  output  1  one-cycle pulse at end of playback.
REQ-019 SHALL have port underrun  output  1  sticky flag: sample_req arrived with FIFO empty while busy.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, ACK, FLUSH.
REQ-021 IDLE: start accepted -> address=0, latch end_address, busy=1, clear underrun, go REQ; start while busy SHALL be ignored.
REQ-022 REQ: when ram_rdy=1 and FIFO not full, assert read_request next cycle and go WAIT; otherwise hold.
REQ-023 WAIT: read_request held high until rd_data_pres=1; then push data_out into FIFO (unless stopping), drop read_request, assert read_ack, go ACK.
REQ-024 ACK: hold read_ack until rd_data_pres=0, then deassert; if address==end_address go FLUSH, else address+1 and go REQ.
REQ-025 FLUSH: wait until FIFO empty, then pulse done for one cycle, busy=0, go IDLE.
REQ-026 Minimum request-to-request spacing SHALL be 3 cycles; start-to-read_request latency 2 cycles with ram_rdy=1.
REQ-027 sample_req with FIFO non-empty SHALL pop the head into sample register next cycle.
REQ-028 sample_req with FIFO empty while busy SHALL set underrun and hold sample unchanged.
REQ-029 Simultaneous push and pop on full FIFO SHALL both succeed; on empty FIFO pop SHALL see underrun, push SHALL succeed.
REQ-030 stop in REQ/FLUSH SHALL flush FIFO and return to IDLE next cycle without done; stop in WAIT/ACK SHALL complete the handshake, discard data, then flush and go IDLE.
REQ-031 Address arithmetic SHALL be ADDR_W-bit unsigned; end_address=0 plays exactly one sample.

Reset
REQ-032 While reset=0: FSM=IDLE, address=0, read_request=0, read_ack=0, sample=0, busy=0, done=0, underrun=0, FIFO empty.
REQ-033 Reset mid-handshake SHALL drop read_request/read_ack immediately (asynchronously).

Configuration
REQ-034 With PLAYBACK_LOOP_EN defined, ACK at address==end_address SHALL wrap address to 0 and go REQ (no done) until stop; without it, behaviour per REQ-024/025.

Structure
REQ-035 Shared package SHALL hold the FSM state enum and ADDR_W/DATA_W defaults shared with the recorder write path.
REQ-036 FIFO SHALL be a sub-module named playback_fifo (registered read, full/empty/count).

Verification
REQ-037 end_address=3, ram_rdy=1, RAM model returns addr^8'hA5, sample_req every 20 cycles -> samples A5,A4,A7,A6 in order, done one pulse, busy=0.
REQ-038 sample_req every cycle, RAM latency 5 -> underrun=1, sample holds last value, no sample lost or duplicated.
REQ-039 ram_rdy=0 for 50 cycles after start -> no read_request until ram_rdy=1.
REQ-040 stop while in WAIT at address 2 -> handshake completes, read_ack pulse seen, FIFO flushed, done=0, busy=0.
REQ-041 reset=0 asserted in ACK -> read_ack low same cycle, all outputs at reset values.
REQ-042 PLAYBACK_LOOP_EN, end_address=1 -> address sequence 0,1,0,1,... until stop; done never asserted.

Source files
------------

// File: rtl/ram_playback_reader_pkg.sv
// Shared definitions for the RAM playback reader and the recorder write path:
// default RAM address/sample widths and the playback FSM state encoding.
package ram_playback_reader_pkg;

  localparam int unsigned PB_ADDR_W = 26;
  localparam int unsigned PB_DATA_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_REQ   = S_REQ,
    ST_WAIT  = S_WAIT,
    ST_ACK   = S_ACK,
    ST_FLUSH = S_FLUSH
  } pb_state_e;

endpackage

// File: rtl/playback_fifo.sv
// Sample buffer between the RAM read path and the DAC strobe: power-of-two
// depth, registered read port that holds its value until the next pop.
module playback_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rdata;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_rdata;

  // A pop frees a slot in the same cycle, so push on full succeeds alongside it.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_do_pop) begin
        r_rdata <= r_mem[r_rd_ptr];
      end
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_do_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/ram_playback_reader.sv
// Streams samples from RAM address 0..end_address into a small FIFO drained by
// the DAC strobe. Define PLAYBACK_LOOP_EN to wrap to address 0 until stopped.
module ram_playback_reader
  import ram_playback_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = PB_ADDR_W,
  parameter int unsigned DATA_W     = PB_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic [ADDR_W-1:0]             end_address,
  input  logic                          ram_rdy,
  output logic [ADDR_W-1:0]             address,
  output logic                          read_request,
  input  logic                          rd_data_pres,
  input  logic [DATA_W-1:0]             data_out,
  output logic                          read_ack,
  input  logic                          sample_req,
  output logic [DATA_W-1:0]             sample,
  output logic                          busy,
  output logic                          done,
  output logic                          underrun,
  output logic [2:0]                    o_dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   o_dbg_fifo_count
);

  pb_state_e         r_state;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] r_end_address;
  logic              r_read_request;
  logic              r_read_ack;
  logic              r_busy;
  logic              r_done;
  logic              r_underrun;
  logic              r_stopping;

  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic              w_at_end;
  logic              w_abort;
  logic [DATA_W-1:0] w_fifo_q;

  // RAM handshake: read_request stays high until rd_data_pres; read_ack then
  // stays high until rd_data_pres falls. Data is taken on the first
  // rd_data_pres cycle, so exactly one word moves per request.
  assign w_at_end = (r_address == r_end_address);
  assign w_abort  = r_stopping | stop;
  assign w_pop    = sample_req & ~w_empty;
  assign w_push   = (r_state == ST_WAIT) & rd_data_pres & ~w_abort;
  assign w_flush  = (((r_state == ST_REQ) || (r_state == ST_FLUSH)) && stop) ||
                    ((r_state == ST_ACK) && !rd_data_pres && w_abort);

  playback_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_wdata (data_out),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_rdata (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_dbg_fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_address      <= '0;
      r_end_address  <= '0;
      r_read_request <= 1'b0;
      r_read_ack     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_underrun     <= 1'b0;
      r_stopping     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (sample_req && w_empty && r_busy) begin
        r_underrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_address     <= '0;
            r_end_address <= end_address;
            r_busy        <= 1'b1;
            r_underrun    <= 1'b0;
            r_stopping    <= 1'b0;
            r_state       <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (ram_rdy && !w_full) begin
            r_read_request <= 1'b1;
            r_state        <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (stop) begin
            r_stopping <= 1'b1;
          end
          if (rd_data_pres) begin
            r_read_request <= 1'b0;
            r_read_ack     <= 1'b1;
            r_state        <= ST_ACK;
          end
        end

        ST_ACK: begin
          if (stop) begin
            r_stopping <= 1'b1;
          end
          if (!rd_data_pres) begin
            r_read_ack <= 1'b0;
            if (w_abort) begin
              r_stopping <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end else if (w_at_end) begin
`ifdef PLAYBACK_LOOP_EN
              r_address <= '0;
              r_state   <= ST_REQ;
`else
              r_state   <= ST_FLUSH;
`endif
            end else begin
              r_address <= r_address + ADDR_W'(1);
              r_state   <= ST_REQ;
            end
          end
        end

        ST_FLUSH: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign address      = r_address;
  assign read_request = r_read_request;
  assign read_ack     = r_read_ack;
  assign sample       = w_fifo_q;
  assign busy         = r_busy;
  assign done         = r_done;
  assign underrun     = r_underrun;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ram_playback_reader.sv
// Bench for ram_playback_reader: behavioural RAM with random latency, random
// DAC strobes, and a queue model of the samples that should come out in order.
module tb_ram_playback_reader;

  localparam int ADDR_W     = 26;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start        = 1'b0;
  logic              stop         = 1'b0;
  logic [ADDR_W-1:0] end_address  = '0;
  logic              ram_rdy      = 1'b0;
  logic              rd_data_pres = 1'b0;
  logic [DATA_W-1:0] data_out     = '0;
  logic              sample_req   = 1'b0;
  logic [ADDR_W-1:0] address;
  logic              read_request;
  logic              read_ack;
  logic [DATA_W-1:0] sample;
  logic              busy;
  logic              done;
  logic              underrun;
  logic [2:0]        dbg_state;
  logic [CNT_W-1:0]  dbg_fifo_count;

  ram_playback_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .end_address      (end_address),
    .ram_rdy          (ram_rdy),
    .address          (address),
    .read_request     (read_request),
    .rd_data_pres     (rd_data_pres),
    .data_out         (data_out),
    .read_ack         (read_ack),
    .sample_req       (sample_req),
    .sample           (sample),
    .busy             (busy),
    .done             (done),
    .underrun         (underrun),
    .o_dbg_state      (dbg_state),
    .o_dbg_fifo_count (dbg_fifo_count)
  );

  // scoreboard state
  int                n_pass  = 0;
  int                n_total = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got[$];
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W-1:0] end_q;
  logic              exp_underrun;
  bit                loop_mode;
  bit                stop_pending;
  int req_cnt, pop_cnt, done_cnt, ack_cnt, pc;
  int sreq_mode, sreq_period, sreq_prob;
  int lat_min, lat_max, cur_lat, lat_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
    cur_lat = $urandom_range(hi, lo);
    lat_cnt = 0;
  endtask

  // One clock: drive strobe + RAM model at negedge, score at posedge+1.
  task automatic tick();
    logic              p_pres, p_ack, p_sreq, p_busy;
    logic [DATA_W-1:0] p_sample, p_data, e;
    @(negedge clk);
    pc++;
    case (sreq_mode)
      1:       sample_req = ((pc % sreq_period) == 0);
      2:       sample_req = ($urandom_range(99, 0) < sreq_prob);
      default: sample_req = 1'b0;
    endcase
    if (rd_data_pres) begin
      if (read_ack) rd_data_pres = 1'b0;
    end else if (read_request && !read_ack) begin
      if (lat_cnt >= cur_lat) begin
        check("req_addr", 32'(address), 32'(exp_addr));
        data_out     = ram_word(address);
        rd_data_pres = 1'b1;
        req_cnt++;
        if (exp_addr == end_q) exp_addr = loop_mode ? '0 : exp_addr;
        else exp_addr = exp_addr + 1'b1;
        lat_cnt = 0;
        cur_lat = $urandom_range(lat_max, lat_min);
      end else begin
        lat_cnt++;
      end
    end
    p_pres = rd_data_pres; p_data = data_out; p_ack = read_ack;
    p_sreq = sample_req;   p_busy = busy;     p_sample = sample;
    @(posedge clk);
    #1;
    if (p_sreq) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sample_pop", 32'(sample), 32'(e));
        got.push_back(sample);
        pop_cnt++;
      end else begin
        if (p_busy) exp_underrun = 1'b1;
        check("sample_hold", 32'(sample), 32'(p_sample));
      end
    end
    if (p_pres && !p_ack && read_ack) begin
      exp_q.push_back(p_data);
      ack_cnt++;
    end
    check("underrun", 32'(underrun), 32'(exp_underrun));
    if (done) done_cnt++;
    if (stop_pending && !busy) begin
      exp_q.delete();
      stop_pending = 1'b0;
    end
  endtask

  // driver tasks
  task automatic start_play(input logic [ADDR_W-1:0] ea);
    end_address  = ea;
    end_q        = ea;
    exp_addr     = '0;
    exp_underrun = 1'b0;
    req_cnt = 0; pop_cnt = 0; done_cnt = 0; ack_cnt = 0; pc = 0;
    got.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] want_a [4];
    logic [ADDR_W-1:0] ea;
    int ack0;
    want_a = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
    loop_mode = 1'b0;
`ifdef PLAYBACK_LOOP_EN
    loop_mode = 1'b1;
`endif
    sreq_mode = 0; sreq_period = 1; sreq_prob = 0; stop_pending = 1'b0;
    exp_underrun = 1'b0; end_q = '0; exp_addr = '0;
    req_cnt = 0; pop_cnt = 0; done_cnt = 0; ack_cnt = 0; pc = 0;
    set_lat(0, 0);

    // reset values
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_address", 32'(address), 32'd0);
    check("rst_read_request", 32'(read_request), 32'd0);
    check("rst_read_ack", 32'(read_ack), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_fifo_count", 32'(dbg_fifo_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();

`ifdef PLAYBACK_LOOP_EN
    // looping playback: addresses 0,1,0,1,... until stop, never done
    ram_rdy = 1'b1; set_lat(0, 3); sreq_mode = 2; sreq_prob = 60;
    start_play(1);
    repeat (80) tick();
    stop = 1'b1; stop_pending = 1'b1;
    tick();
    stop = 1'b0; sreq_mode = 0;
    run_until_idle("L", 100);
    check("L_no_done", 32'(done_cnt), 32'd0);
    check("L_wrapped", 32'(req_cnt >= 6), 32'd1);
    check("L_fifo_flushed", 32'(dbg_fifo_count), 32'd0);
`else
    // basic four-sample playback, slow strobe
    ram_rdy = 1'b1; set_lat(0, 0); sreq_mode = 1; sreq_period = 20;
    start_play(3);
    check("A_rr_lat1", 32'(read_request), 32'd0);
    tick();
    check("A_rr_lat2", 32'(read_request), 32'd1);
    run_until_idle("A", 300);
    check("A_n_samples", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("A_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(want_a[i]));
    check("A_done_pulses", 32'(done_cnt), 32'd1);
    check("A_underrun", 32'(underrun), 32'd0);
    check("A_req_cnt", 32'(req_cnt), 32'd4);

    // strobe every cycle, slow RAM -> underrun, nothing lost or duplicated
    sreq_mode = 0; repeat (3) tick();
    set_lat(5, 5); sreq_mode = 1; sreq_period = 1;
    start_play(5);
    run_until_idle("B", 500);
    check("B_underrun", 32'(underrun), 32'd1);
    check("B_pop_cnt", 32'(pop_cnt), 32'd6);
    check("B_done_pulses", 32'(done_cnt), 32'd1);
    sreq_mode = 0; repeat (2) tick();

    // randomized trials including a single-sample playback
    for (int t = 0; t < 5; t++) begin
      ea = (t == 0) ? '0 : ADDR_W'($urandom_range(12, 1));
      set_lat(0, 6); sreq_mode = 2; sreq_prob = $urandom_range(80, 10);
      start_play(ea);
      run_until_idle("R", 3000);
      check("R_pop_cnt", 32'(pop_cnt), 32'(ea) + 32'd1);
      check("R_req_cnt", 32'(req_cnt), 32'(ea) + 32'd1);
      check("R_done_pulses", 32'(done_cnt), 32'd1);
      check("R_model_empty", 32'(exp_q.size()), 32'd0);
      sreq_mode = 0; repeat (2) tick();
    end

    // RAM not ready for 50 cycles after start
    ram_rdy = 1'b0; set_lat(3, 3);
    start_play(2);
    ack0 = 0;
    repeat (50) begin
      tick();
      if (read_request) ack0 = 1;
    end
    check("C_no_req_while_not_rdy", 32'(ack0), 32'd0);
    ram_rdy = 1'b1;
    tick();
    check("C_req_after_rdy", 32'(read_request), 32'd1);
    sreq_mode = 2; sreq_prob = 50;
    run_until_idle("C", 1000);
    check("C_done_pulses", 32'(done_cnt), 32'd1);
    sreq_mode = 0; repeat (2) tick();

    // stop while waiting for RAM ready (REQ)
    ram_rdy = 1'b0;
    start_play(3);
    tick();
    stop = 1'b1; stop_pending = 1'b1;
    tick();
    stop = 1'b0;
    check("S_req_busy", 32'(busy), 32'd0);
    check("S_req_state", 32'(dbg_state), 32'd0);
    check("S_req_no_done", 32'(done_cnt), 32'd0);
    ram_rdy = 1'b1;

    // stop while in WAIT at address 2
    set_lat(4, 4);
    start_play(5);
    for (int i = 0; i < 100 && !(read_request && address == 2); i++) tick();
    check("D_in_wait_addr2", 32'(read_request && address == 2), 32'd1);
    ack0 = ack_cnt;
    stop = 1'b1; stop_pending = 1'b1;
    tick();
    stop = 1'b0;
    run_until_idle("D", 100);
    check("D_ack_pulse", 32'(ack_cnt - ack0), 32'd1);
    check("D_no_done", 32'(done_cnt), 32'd0);
    check("D_fifo_flushed", 32'(dbg_fifo_count), 32'd0);
    sreq_mode = 1; sreq_period = 1;
    repeat (3) tick();
    sreq_mode = 0;
    check("D_underrun", 32'(underrun), 32'd0);

    // reset asserted in ACK
    set_lat(2, 2);
    start_play(3);
    for (int i = 0; i < 100 && !read_ack; i++) tick();
    check("E_in_ack", 32'(read_ack), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("E_read_ack", 32'(read_ack), 32'd0);
    check("E_read_request", 32'(read_request), 32'd0);
    check("E_busy", 32'(busy), 32'd0);
    check("E_address", 32'(address), 32'd0);
    check("E_sample", 32'(sample), 32'd0);
    check("E_state", 32'(dbg_state), 32'd0);
    check("E_fifo_count", 32'(dbg_fifo_count), 32'd0);
    rd_data_pres = 1'b0; exp_q.delete(); exp_underrun = 1'b0; stop_pending = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
